// File: rtl/can_filter_pkg.sv
// Shared types for the CAN acceptance filter: frame, filter entry and the
// word stored in the output FIFO, plus the single-entry match rule.
package can_filter_pkg;

  localparam int CAN_ID_W   = 29;
  localparam int CAN_DATA_W = 64;
  localparam int HIT_IDX_W  = 5;  // enough for up to 32 entries

  typedef struct packed {
    logic [CAN_ID_W-1:0]   id;
    logic                  ext;
    logic                  rtr;
    logic [3:0]            dlc;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

  typedef struct packed {
    logic                en;
    logic                ext;
    logic [CAN_ID_W-1:0] match;
    logic [CAN_ID_W-1:0] mask;
  } filt_entry_t;

  typedef struct packed {
    can_frame_t           frame;
    logic                 hit;
    logic [HIT_IDX_W-1:0] hit_idx;
  } fifo_word_t;

  // Mask bit 1 means the ID bit takes part in the comparison.
  function automatic logic entry_match(filt_entry_t e, can_frame_t f);
    return e.en && (e.ext == f.ext) && (((f.id ^ e.match) & e.mask) == '0);
  endfunction

endpackage

// File: rtl/can_frame_fifo.sv
// Generic synchronous show-ahead FIFO: the head word is visible on dout_o
// whenever the FIFO is non-empty; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module can_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = level_q;
  // Head reads as zero while empty so the frame fields are clean after reset.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/can_id_filter.sv
// CAN acceptance filter: capture -> compare against the entry table ->
// output FIFO, with saturating pass/drop/overflow statistics.
module can_id_filter
  import can_filter_pkg::*;
#(
  parameter int N_FILTERS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32,
  localparam int IDX_W     = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [28:0]       in_id_i,
  input  logic              in_ext_i,
  input  logic              in_rtr_i,
  input  logic [3:0]        in_dlc_i,
  input  logic [63:0]       in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [28:0]       out_id_o,
  output logic              out_ext_o,
  output logic              out_rtr_o,
  output logic [3:0]        out_dlc_o,
  output logic [63:0]       out_data_o,
  output logic              out_hit_o,
  output logic [IDX_W-1:0]  out_hit_idx_o,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic              cfg_en_i,
  input  logic              cfg_ext_i,
  input  logic [28:0]       cfg_match_i,
  input  logic [28:0]       cfg_mask_i,
  input  logic              default_pass_i,
  output logic [LVL_W-1:0]  fifo_level_o,
  output logic [CNT_W-1:0]  cnt_pass_o,
  output logic [CNT_W-1:0]  cnt_drop_o,
  output logic [CNT_W-1:0]  cnt_ovf_o
);

  // Handshakes: the input side is a pulse per frame (in_ready is only low in
  // reset); the output side transfers the head when out_valid && out_ready.
  filt_entry_t          entry_q [N_FILTERS];
  logic                 in_ready_q;
  logic                 s1_valid_q;
  can_frame_t           s1_frame_q;
  logic                 hit_d;
  logic [HIT_IDX_W-1:0] hit_idx_d;
  logic                 fwd, pop, ovf_ev, pass_ev, drop_ev;
  logic                 fifo_full, fifo_empty;
  fifo_word_t           push_word, head;
  logic [$bits(fifo_word_t)-1:0] head_bits;
  logic [CNT_W-1:0]     cnt_pass_q, cnt_drop_q, cnt_ovf_q;
  logic                 unused_hit_idx_bits;

  assign in_ready_o = in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_frame_q <= '0;
    end else begin
      in_ready_q <= 1'b1;
      s1_valid_q <= in_valid_i && in_ready_q;
      if (in_valid_i && in_ready_q)
        s1_frame_q <= '{id: in_id_i, ext: in_ext_i, rtr: in_rtr_i,
                        dlc: in_dlc_i, data: in_data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_FILTERS; k++) entry_q[k] <= '0;
    end else if (cfg_we_i && (32'(cfg_idx_i) < N_FILTERS)) begin
      entry_q[cfg_idx_i] <= '{en: cfg_en_i, ext: cfg_ext_i,
                              match: cfg_match_i, mask: cfg_mask_i};
    end
  end

  // Scan from the top so the lowest matching index is the last one assigned.
  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = '0;
    for (int k = N_FILTERS - 1; k >= 0; k--) begin
      if (entry_match(entry_q[k], s1_frame_q)) begin
        hit_d     = 1'b1;
        hit_idx_d = HIT_IDX_W'(k);
      end
    end
  end

  assign fwd     = s1_valid_q && (hit_d || default_pass_i);
  assign pop     = out_valid_o && out_ready_i;
  assign ovf_ev  = fwd && fifo_full && !pop;
  assign pass_ev = fwd && !ovf_ev;
  assign drop_ev = s1_valid_q && !hit_d && !default_pass_i;

  assign push_word = '{frame: s1_frame_q, hit: hit_d, hit_idx: hit_idx_d};

  can_frame_fifo #(
    .WIDTH($bits(fifo_word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fwd),
    .din_i  (push_word),
    .pop_i  (pop),
    .dout_o (head_bits),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level_o)
  );

  assign head                = fifo_word_t'(head_bits);
  assign out_valid_o         = !fifo_empty;
  assign out_id_o            = head.frame.id;
  assign out_ext_o           = head.frame.ext;
  assign out_rtr_o           = head.frame.rtr;
  assign out_dlc_o           = head.frame.dlc;
  assign out_data_o          = head.frame.data;
  assign out_hit_o           = head.hit;
  assign out_hit_idx_o       = head.hit_idx[IDX_W-1:0];
  assign unused_hit_idx_bits = ^head.hit_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_pass_q <= '0;
      cnt_drop_q <= '0;
      cnt_ovf_q  <= '0;
    end else begin
      if (pass_ev && (cnt_pass_q != '1)) cnt_pass_q <= cnt_pass_q + CNT_W'(1);
      if (drop_ev && (cnt_drop_q != '1)) cnt_drop_q <= cnt_drop_q + CNT_W'(1);
      if (ovf_ev  && (cnt_ovf_q  != '1)) cnt_ovf_q  <= cnt_ovf_q  + CNT_W'(1);
    end
  end

  assign cnt_pass_o = cnt_pass_q;
  assign cnt_drop_o = cnt_drop_q;
  assign cnt_ovf_o  = cnt_ovf_q;

endmodule

// File: tb/tb_can_id_filter.sv
// Randomised + directed bench for can_id_filter: a queue-based reference
// model produces expected output frames; a negedge monitor compares them.
module tb_can_id_filter;
  import can_filter_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  localparam int IDX_W = 3;
  localparam int LVL_W = 5;
  localparam int W     = $bits(fifo_word_t);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [28:0]       in_id_i = '0;
  logic              in_ext_i = 1'b0;
  logic              in_rtr_i = 1'b0;
  logic [3:0]        in_dlc_i = '0;
  logic [63:0]       in_data_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b1;
  logic [28:0]       out_id_o;
  logic              out_ext_o, out_rtr_o;
  logic [3:0]        out_dlc_o;
  logic [63:0]       out_data_o;
  logic              out_hit_o;
  logic [IDX_W-1:0]  out_hit_idx_o;
  logic              cfg_we_i = 1'b0;
  logic [IDX_W-1:0]  cfg_idx_i = '0;
  logic              cfg_en_i = 1'b0;
  logic              cfg_ext_i = 1'b0;
  logic [28:0]       cfg_match_i = '0;
  logic [28:0]       cfg_mask_i = '0;
  logic              default_pass_i = 1'b0;
  logic [LVL_W-1:0]  fifo_level_o;
  logic [CNT_W-1:0]  cnt_pass_o, cnt_drop_o, cnt_ovf_o;

  always #5 clk = ~clk;

  can_id_filter #(.N_FILTERS(N), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_id_i(in_id_i), .in_ext_i(in_ext_i), .in_rtr_i(in_rtr_i),
    .in_dlc_i(in_dlc_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_id_o(out_id_o), .out_ext_o(out_ext_o), .out_rtr_o(out_rtr_o),
    .out_dlc_o(out_dlc_o), .out_data_o(out_data_o),
    .out_hit_o(out_hit_o), .out_hit_idx_o(out_hit_idx_o),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_en_i(cfg_en_i),
    .cfg_ext_i(cfg_ext_i), .cfg_match_i(cfg_match_i), .cfg_mask_i(cfg_mask_i),
    .default_pass_i(default_pass_i), .fifo_level_o(fifo_level_o),
    .cnt_pass_o(cnt_pass_o), .cnt_drop_o(cnt_drop_o), .cnt_ovf_o(cnt_ovf_o)
  );

  // ---------------- reference model ----------------
  logic        m_en    [N];
  logic        m_ext   [N];
  logic [28:0] m_match [N];
  logic [28:0] m_mask  [N];
  logic [W-1:0] exp_q[$];
  logic         stage_v = 1'b0;
  logic         stage_fwd = 1'b0;
  logic [W-1:0] stage_w = '0;
  logic         m_rdy = 1'b0;
  int           m_pass = 0, m_drop = 0, m_ovf = 0;
  int           vectors = 0, miscompares = 0;
  logic         mon_en = 1'b0;
  logic [63:0]  last_pop_data = '0;

  // The first enabled entry (ascending index) whose type agrees and whose
  // masked ID bits equal the programmed ones decides the frame.
  function automatic fifo_word_t ref_eval();
    fifo_word_t w;
    w.frame.id   = in_id_i;
    w.frame.ext  = in_ext_i;
    w.frame.rtr  = in_rtr_i;
    w.frame.dlc  = in_dlc_i;
    w.frame.data = in_data_i;
    w.hit        = 1'b0;
    w.hit_idx    = '0;
    for (int k = 0; k < N; k++) begin
      if (m_en[k] && m_ext[k] == in_ext_i &&
          ((in_id_i & m_mask[k]) == (m_match[k] & m_mask[k]))) begin
        w.hit     = 1'b1;
        w.hit_idx = 5'(k);
        break;
      end
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_en[k] = 1'b0; m_ext[k] = 1'b0; m_match[k] = '0; m_mask[k] = '0;
      end
      exp_q.delete();
      stage_v = 1'b0;
      m_rdy = 1'b0;
      m_pass = 0; m_drop = 0; m_ovf = 0;
    end else begin
      if (out_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
      if (stage_v) begin
        if (!stage_fwd) m_drop++;
        else if (exp_q.size() < DEPTH) begin exp_q.push_back(stage_w); m_pass++; end
        else m_ovf++;
      end
      if (cfg_we_i && int'(cfg_idx_i) < N) begin
        m_en[cfg_idx_i] = cfg_en_i; m_ext[cfg_idx_i] = cfg_ext_i;
        m_match[cfg_idx_i] = cfg_match_i; m_mask[cfg_idx_i] = cfg_mask_i;
      end
      stage_v = in_valid_i && m_rdy;
      if (stage_v) begin
        fifo_word_t w;
        w = ref_eval();
        stage_w = W'(w);
        stage_fwd = w.hit || default_pass_i;
      end
      m_rdy = 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 128'(out_valid_o), 128'(exp_q.size() != 0));
      if (out_valid_o && exp_q.size() > 0) begin
        fifo_word_t a;
        a.frame.id = out_id_o; a.frame.ext = out_ext_o; a.frame.rtr = out_rtr_o;
        a.frame.dlc = out_dlc_o; a.frame.data = out_data_o;
        a.hit = out_hit_o; a.hit_idx = 5'(out_hit_idx_o);
        chk("head", 128'(a), 128'(exp_q[0]));
        if (out_ready_i) last_pop_data = out_data_o;
      end
    end
  end

  task automatic check_stats(input string tag);
    chk({tag, ".cnt_pass"}, 128'(cnt_pass_o), 128'(m_pass));
    chk({tag, ".cnt_drop"}, 128'(cnt_drop_o), 128'(m_drop));
    chk({tag, ".cnt_ovf"},  128'(cnt_ovf_o),  128'(m_ovf));
    chk({tag, ".level"},    128'(fifo_level_o), 128'(exp_q.size()));
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    cfg_we_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drive_frame(input logic [28:0] id, input logic ext, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] data);
    in_valid_i = 1'b1; in_id_i = id; in_ext_i = ext; in_rtr_i = rtr;
    in_dlc_i = dlc; in_data_i = data;
  endtask

  task automatic drive_cfg(input logic [IDX_W-1:0] idx, input logic en, input logic ext,
                           input logic [28:0] match, input logic [28:0] mask);
    cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_en_i = en; cfg_ext_i = ext;
    cfg_match_i = match; cfg_mask_i = mask;
  endtask

  task automatic drive_rand_frame();
    int k;
    logic ext;
    logic [28:0] id;
    k   = $urandom_range(0, N - 1);
    ext = m_ext[k];
    if ($urandom_range(0, 3) == 0) ext = 1'($urandom_range(0, 1));
    id = (m_match[k] & m_mask[k]) | (29'($urandom) & ~m_mask[k]);
    if ($urandom_range(0, 4) == 0) id = 29'($urandom);
    if (!ext) id = {18'd0, id[10:0]};
    drive_frame(id, ext, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 8)),
                {$urandom, $urandom});
  endtask

  task automatic drive_rand_cfg();
    logic ext;
    logic [28:0] match, mask;
    ext   = 1'($urandom_range(0, 1));
    match = 29'($urandom);
    mask  = 29'($urandom);
    if (!ext) begin match = match & 29'h7FF; mask = mask & 29'h7FF; end
    drive_cfg(IDX_W'($urandom_range(0, N - 1)), $urandom_range(0, 3) != 0, ext, match, mask);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] x_data;
    rst = 1'b1;
    out_ready_i = 1'b1;
    idle(3);
    chk("in_ready_in_reset", 128'(in_ready_o), 128'(0));
    rst = 1'b0;
    step();
    mon_en = 1'b1;
    chk("in_ready_after_reset", 128'(in_ready_o), 128'(1));
    chk("out_id_after_reset", 128'(out_id_o), 128'(0));
    check_stats("reset");

    // Single standard entry: one hit, one miss, hit visible two cycles later.
    default_pass_i = 1'b0;
    drive_cfg(0, 1'b1, 1'b0, 29'h123, 29'h7FF);
    step();
    drive_frame(29'h123, 1'b0, 1'b0, 4'd8, 64'h0706050403020100);
    step();
    drive_frame(29'h124, 1'b0, 1'b0, 4'd2, 64'h00000000000000AA);
    step();
    chk("t1_latency_valid", 128'(out_valid_o), 128'(1));
    chk("t1_latency_id", 128'(out_id_o), 128'(29'h123));
    chk("t1_hit", 128'({out_hit_o, out_hit_idx_o}), 128'({1'b1, 3'd0}));
    idle(4);
    chk("t1_pass", 128'(cnt_pass_o), 128'(1));
    chk("t1_drop", 128'(cnt_drop_o), 128'(1));

    // Two overlapping extended entries: lowest index wins.
    drive_cfg(2, 1'b1, 1'b1, 29'h18FF0000, 29'h1FFF0000);
    step();
    drive_cfg(5, 1'b1, 1'b1, 29'h18FF1234, 29'h1FFFFFFF);
    step();
    drive_frame(29'h18FF1234, 1'b1, 1'b0, 4'd4, 64'hDEADBEEF);
    step();
    step();
    chk("t2_hit_idx", 128'({out_valid_o, out_hit_o, out_hit_idx_o}), 128'({2'b11, 3'd2}));
    drive_frame(29'h18FF1234, 1'b0, 1'b0, 4'd4, 64'hDEADBEEF);
    idle(4);
    chk("t2_drop", 128'(cnt_drop_o), 128'(2));
    check_stats("t2");

    // Nothing enabled, default pass forwards everything.
    for (int k = 0; k < N; k++) begin
      drive_cfg(IDX_W'(k), 1'b0, 1'b0, '0, '0);
      step();
    end
    default_pass_i = 1'b1;
    idle(2);
    for (int i = 0; i < 3; i++) begin drive_rand_frame(); step(); end
    idle(4);
    chk("t3_pass", 128'(cnt_pass_o), 128'(5));
    check_stats("t3");

    // Overflow: 20 frames into a stalled 16-deep FIFO.
    default_pass_i = 1'b0;
    drive_cfg(0, 1'b1, 1'b0, 29'h123, 29'h7FF);
    step();
    out_ready_i = 1'b0;
    idle(2);
    for (int i = 0; i < 20; i++) begin
      drive_frame(29'h123, 1'b0, 1'b0, 4'd8, 64'(i));
      step();
    end
    idle(3);
    chk("t4_level", 128'(fifo_level_o), 128'(16));
    chk("t4_ovf", 128'(cnt_ovf_o), 128'(4));
    out_ready_i = 1'b1;
    idle(20);
    check_stats("t4");

    // Full FIFO, pop and push in the same cycle: no overflow.
    out_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_frame(29'h123, 1'b0, 1'b0, 4'd1, 64'h100 + 64'(i));
      step();
    end
    idle(3);
    x_data = 64'hCAFEF00D12345678;
    drive_frame(29'h123, 1'b0, 1'b1, 4'd3, x_data);
    step();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    step();
    chk("t5_level", 128'(fifo_level_o), 128'(16));
    chk("t5_ovf", 128'(cnt_ovf_o), 128'(4));
    out_ready_i = 1'b1;
    idle(20);
    chk("t5_last_frame", 128'(last_pop_data), 128'(x_data));
    check_stats("t5");

    // Config write while a frame sits in the compare stage.
    drive_frame(29'h1A3, 1'b0, 1'b0, 4'd1, 64'h1);
    step();
    drive_cfg(0, 1'b1, 1'b0, 29'h123, 29'h07F);
    drive_frame(29'h1A3, 1'b0, 1'b0, 4'd1, 64'h2);
    step();
    idle(4);
    chk("t6_drop", 128'(cnt_drop_o), 128'(3));
    chk("t6_pass", 128'(cnt_pass_o), 128'(39));
    check_stats("t6");

    // Random traffic with random config writes and back-pressure.
    for (int phase = 0; phase < 2; phase++) begin
      default_pass_i = 1'(phase);
      idle(3);
      for (int c = 0; c < 300; c++) begin
        out_ready_i = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 9) < 7) drive_rand_frame();
        if ($urandom_range(0, 9) == 0) drive_rand_cfg();
        step();
      end
      out_ready_i = 1'b1;
      idle(25);
      check_stats("random");
    end

    // Reset in the middle of a burst.
    out_ready_i = 1'b0;
    default_pass_i = 1'b1;
    for (int i = 0; i < 6; i++) begin drive_rand_frame(); step(); end
    drive_rand_frame();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("rst_level", 128'(fifo_level_o), 128'(0));
    chk("rst_counters", 128'({cnt_pass_o, cnt_drop_o, cnt_ovf_o}), 128'(0));
    idle(2);
    out_ready_i = 1'b1;
    default_pass_i = 1'b0;
    drive_frame(29'h123, 1'b0, 1'b0, 4'd0, 64'h0);
    step();
    idle(4);
    chk("post_rst_drop", 128'(cnt_drop_o), 128'(1));
    check_stats("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
